// File: rtl/corr_pkg.sv
// Shared types and width helpers for the correlation MAC engine.
// The CORR_SAT_EN macro (see corr_mac_engine.sv) selects saturating accumulation.
package corr_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } corr_state_t;

    localparam int DEF_DATA_W = 4;
    localparam int DEF_DEPTH  = 16;

    function automatic int idxWidth(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int prodWidth(input int dataW);
        return 2 * dataW;
    endfunction

    localparam int IDX_W  = idxWidth(DEF_DEPTH);
    localparam int PROD_W = prodWidth(DEF_DATA_W);

endpackage

// File: rtl/corr_tick_gen.sv
// Step pacer: pulses o_tick once every TICK_DIV enabled clocks; i_clr restarts the count.
module corr_tick_gen #(
    parameter int TICK_DIV = 15000000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= (r_count == LAST) ? '0 : r_count + 1'b1;
        end
    end

    assign o_tick = i_en && (r_count == LAST);

endmodule

// File: rtl/corr_mac_engine.sv
// Paced unsigned dot-product engine over two loadable sample memories.
// Define CORR_SAT_EN to saturate the accumulator instead of wrapping.
module corr_mac_engine
    import corr_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int SEL_W    = 2,
    parameter int ACC_W    = 12,
    parameter int TICK_DIV = 15000000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_start,
    input  logic [SEL_W-1:0]         i_n_sel,
    input  logic                     i_load_en,
    input  logic [$clog2(DEPTH)-1:0] i_load_addr,
    input  logic [DATA_W-1:0]        i_load_a,
    input  logic [DATA_W-1:0]        i_load_b,
    output logic                     o_busy,
    output logic                     o_done,
    output logic [ACC_W-1:0]         o_result,
    output logic                     o_overflow
);

    localparam int MEM_AW = idxWidth(DEPTH);
    localparam int MUL_W  = prodWidth(DATA_W);
    localparam logic [ACC_W-1:0] ACC_MAX = '1;

    corr_state_t r_state;
    corr_state_t w_nextState;

    logic [MEM_AW-1:0] r_idx;
    logic [MEM_AW-1:0] r_lastIdx;
    logic [MEM_AW-1:0] w_lastIdx;
    logic [ACC_W-1:0]  r_result;
    logic [ACC_W-1:0]  w_accNext;
    logic              r_overflow;
    logic [DATA_W-1:0] r_memA [DEPTH];
    logic [DATA_W-1:0] r_memB [DEPTH];
    logic              w_tick;
    logic              w_accept;
    logic              w_step;
    logic              w_last;
    logic              w_carry;
    logic [MUL_W-1:0]  w_prod;
    logic [ACC_W:0]    w_sum;

    corr_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .i_clr (r_state != ACCUM),
        .i_en  (r_state == ACCUM),
        .o_tick(w_tick)
    );

    assign w_accept = (r_state == IDLE) && i_start;
    assign w_step   = (r_state == ACCUM) && w_tick;
    assign w_last   = (r_idx == r_lastIdx);

    // N-1 index: 2^n_sel - 1, clamped to the last memory entry.
    always_comb begin
        w_lastIdx = '1;
        if (32'(i_n_sel) < 32'(MEM_AW)) begin
            w_lastIdx = MEM_AW'((32'd1 << i_n_sel) - 32'd1);
        end
    end

    assign w_prod  = MUL_W'(r_memA[r_idx]) * MUL_W'(r_memB[r_idx]);
    assign w_sum   = {1'b0, r_result} + (ACC_W + 1)'(w_prod);
    assign w_carry = w_sum[ACC_W];

`ifdef CORR_SAT_EN
    assign w_accNext = w_carry ? ACC_MAX : w_sum[ACC_W-1:0];
`else
    assign w_accNext = w_sum[ACC_W-1:0];
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_nextState = ACCUM;
                end
            end
            ACCUM: begin
                o_busy = 1'b1;
                if (w_tick && w_last) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                o_busy      = 1'b1;
                o_done      = 1'b1;
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Result and overflow are held in IDLE until the next accepted start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idx      <= '0;
            r_lastIdx  <= '0;
            r_result   <= '0;
            r_overflow <= 1'b0;
        end else if (w_accept) begin
            r_idx      <= '0;
            r_lastIdx  <= w_lastIdx;
            r_result   <= '0;
            r_overflow <= 1'b0;
        end else if (w_step) begin
            r_idx    <= r_idx + 1'b1;
            r_result <= w_accNext;
            if (w_carry) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Sample memories are not reset and accept writes only while idle.
    always_ff @(posedge clk) begin
        if ((r_state == IDLE) && i_load_en) begin
            r_memA[i_load_addr] <= i_load_a;
            r_memB[i_load_addr] <= i_load_b;
        end
    end

    assign o_result   = r_result;
    assign o_overflow = r_overflow;

endmodule

// File: tb/tb_corr_mac_engine.sv
// Directed bench for corr_mac_engine: three instances cover the main, overflow and clamp/pacing cases.
module tb_corr_mac_engine;

`ifdef CORR_SAT_EN
    localparam int EXP_T3 = 255;
`else
    localparam int EXP_T3 = 16;
`endif

    logic clk = 1'b0;
    logic reset;
    logic loadEn;
    logic [3:0] loadAddr;
    logic [3:0] loadA;
    logic [3:0] loadB;
    logic [2:0] nSel;

    logic start0, start1, start2;
    logic busy0, busy1, busy2;
    logic done0, done1, done2;
    logic ovf0, ovf1, ovf2;
    logic [11:0] result0;
    logic [7:0]  result1;
    logic [11:0] result2;

    int checkCount = 0;
    int errorCount = 0;

    always #5 clk = ~clk;

    corr_mac_engine #(.DATA_W(4), .DEPTH(16), .SEL_W(2), .ACC_W(12), .TICK_DIV(1)) u0 (
        .clk(clk), .reset(reset), .i_start(start0), .i_n_sel(nSel[1:0]),
        .i_load_en(loadEn), .i_load_addr(loadAddr), .i_load_a(loadA), .i_load_b(loadB),
        .o_busy(busy0), .o_done(done0), .o_result(result0), .o_overflow(ovf0)
    );

    corr_mac_engine #(.DATA_W(4), .DEPTH(16), .SEL_W(3), .ACC_W(8), .TICK_DIV(1)) u1 (
        .clk(clk), .reset(reset), .i_start(start1), .i_n_sel(nSel),
        .i_load_en(loadEn), .i_load_addr(loadAddr), .i_load_a(loadA), .i_load_b(loadB),
        .o_busy(busy1), .o_done(done1), .o_result(result1), .o_overflow(ovf1)
    );

    corr_mac_engine #(.DATA_W(4), .DEPTH(4), .SEL_W(2), .ACC_W(12), .TICK_DIV(3)) u2 (
        .clk(clk), .reset(reset), .i_start(start2), .i_n_sel(nSel[1:0]),
        .i_load_en(loadEn), .i_load_addr(loadAddr[1:0]), .i_load_a(loadA), .i_load_b(loadB),
        .o_busy(busy2), .o_done(done2), .o_result(result2), .o_overflow(ovf2)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic logic getBusy(input int k);
        case (k)
            0:       return busy0;
            1:       return busy1;
            default: return busy2;
        endcase
    endfunction

    function automatic logic getDone(input int k);
        case (k)
            0:       return done0;
            1:       return done1;
            default: return done2;
        endcase
    endfunction

    function automatic logic getOvf(input int k);
        case (k)
            0:       return ovf0;
            1:       return ovf1;
            default: return ovf2;
        endcase
    endfunction

    function automatic logic [31:0] getResult(input int k);
        case (k)
            0:       return {20'd0, result0};
            1:       return {24'd0, result1};
            default: return {20'd0, result2};
        endcase
    endfunction

    task automatic setStart(input int k, input logic v);
        case (k)
            0:       start0 = v;
            1:       start1 = v;
            default: start2 = v;
        endcase
    endtask

    // Writes one entry into every idle instance; called at a negedge.
    task automatic applyStimulus(input int addr, input int a, input int b);
        loadEn   = 1'b1;
        loadAddr = 4'(addr);
        loadA    = 4'(a);
        loadB    = 4'(b);
        @(negedge clk);
        loadEn   = 1'b0;
    endtask

    // Counts negedges until done; index 1 is the negedge right after the start edge.
    task automatic waitDone(input int k, input logic dropStart, input int budget, output int cyc);
        cyc = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (dropStart && i == 1) setStart(k, 1'b0);
            if (getDone(k)) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic runAndCheck(input int k, input string tag, input int expCyc,
                               input int expResult, input int expOvf, input int budget);
        int cyc;
        setStart(k, 1'b1);
        waitDone(k, 1'b1, budget, cyc);
        checkOutput({tag, "_cycles"}, cyc, expCyc);
        checkOutput({tag, "_result"}, getResult(k), expResult);
        checkOutput({tag, "_overflow"}, {31'd0, getOvf(k)}, expOvf);
        checkOutput({tag, "_busyAtDone"}, {31'd0, getBusy(k)}, 1);
        @(negedge clk);
        checkOutput({tag, "_busyAfter"}, {31'd0, getBusy(k)}, 0);
        checkOutput({tag, "_doneAfter"}, {31'd0, getDone(k)}, 0);
        checkOutput({tag, "_resultHeld"}, getResult(k), expResult);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cyc;
        int doneSeen;
        reset = 1'b0;
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        loadEn = 1'b0; loadAddr = '0; loadA = '0; loadB = '0; nSel = '0;
        repeat (2) @(negedge clk);

        for (int k = 0; k < 3; k++) begin
            checkOutput("reset_busy", {31'd0, getBusy(k)}, 0);
            checkOutput("reset_done", {31'd0, getDone(k)}, 0);
            checkOutput("reset_result", getResult(k), 0);
            checkOutput("reset_overflow", {31'd0, getOvf(k)}, 0);
        end
        reset = 1'b1;
        @(negedge clk);

        // Scenario 1: 0+1+4+9 = 14
        for (int i = 0; i < 16; i++) applyStimulus(i, (i < 4) ? i : 0, (i < 4) ? i : 0);
        nSel = 3'd2;
        runAndCheck(0, "t1", 5, 14, 0, 20);

        // Scenario 2: single step 15*15
        applyStimulus(0, 15, 15);
        nSel = 3'd0;
        runAndCheck(0, "t2", 2, 225, 0, 10);
        applyStimulus(0, 0, 0);

        // Scenario 4: start, n_sel and load_en mid-run are ignored
        nSel = 3'd2;
        setStart(0, 1'b1);
        @(negedge clk);
        start0 = 1'b0;
        @(negedge clk);
        start0 = 1'b1; nSel = 3'd0;
        loadEn = 1'b1; loadAddr = 4'd1; loadA = 4'd15; loadB = 4'd15;
        @(negedge clk);
        start0 = 1'b0; nSel = 3'd2; loadEn = 1'b0;
        checkOutput("t4_busyMid", {31'd0, busy0}, 1);
        waitDone(0, 1'b0, 10, cyc);
        checkOutput("t4_cycles", cyc + 3, 5);
        checkOutput("t4_result", {20'd0, result0}, 14);
        @(negedge clk);
        checkOutput("t4_busyAfter", {31'd0, busy0}, 0);
        runAndCheck(0, "t4_rerun", 5, 14, 0, 20);

        // Scenario 5: reset at idx=2 aborts the run
        setStart(0, 1'b1);
        @(negedge clk);
        start0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("t5_partial", {20'd0, result0}, 1);
        checkOutput("t5_busyMid", {31'd0, busy0}, 1);
        reset = 1'b0;
        #1;
        checkOutput("t5_rstBusy", {31'd0, busy0}, 0);
        checkOutput("t5_rstResult", {20'd0, result0}, 0);
        checkOutput("t5_rstDone", {31'd0, done0}, 0);
        @(negedge clk);
        reset = 1'b1;
        doneSeen = 0;
        repeat (8) begin
            @(negedge clk);
            if (done0) doneSeen++;
        end
        checkOutput("t5_noDone", doneSeen, 0);
        checkOutput("t5_idleBusy", {31'd0, busy0}, 0);
        runAndCheck(0, "t5_rerun", 5, 14, 0, 20);

        // Scenario 3: 16 * 225 = 3600 into 8 bits
        for (int i = 0; i < 16; i++) applyStimulus(i, 15, 15);
        nSel = 3'd4;
        runAndCheck(1, "t3", 17, EXP_T3, 1, 40);

        // Clamp and pacing on the 4-deep, TICK_DIV=3 instance: 5+12+21+32 = 70
        applyStimulus(0, 1, 5);
        applyStimulus(1, 2, 6);
        applyStimulus(2, 3, 7);
        applyStimulus(3, 4, 8);
        nSel = 3'd3;
        runAndCheck(2, "t2_clamp", 13, 70, 0, 30);

        // Scenario 6: N=2, start held high for back-to-back runs
        nSel = 3'd1;
        start2 = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("t6_beforeStep", {20'd0, result2}, 0);
        @(negedge clk);
        checkOutput("t6_firstStep", {20'd0, result2}, 5);
        waitDone(2, 1'b0, 20, cyc);
        checkOutput("t6_cycles", cyc + 4, 7);
        checkOutput("t6_result", {20'd0, result2}, 17);
        @(negedge clk);
        checkOutput("t6_idleBusy", {31'd0, busy2}, 0);
        checkOutput("t6_idleDone", {31'd0, done2}, 0);
        @(negedge clk);
        checkOutput("t6_restartBusy", {31'd0, busy2}, 1);
        checkOutput("t6_restartClear", {20'd0, result2}, 0);
        start2 = 1'b0;
        waitDone(2, 1'b0, 20, cyc);
        checkOutput("t6_secondCycles", cyc + 9, 15);
        checkOutput("t6_secondResult", {20'd0, result2}, 17);
        @(negedge clk);
        checkOutput("t6_finalBusy", {31'd0, busy2}, 0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
